// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the main decoder. Holds the PC, issues
//   word requests to instruction memory, buffers the returned words together
//   with their PC, and presents them to decode over a valid/ready handshake.
//   A redirect from execute restarts fetch at a new PC. Words that are still
//   in flight when the redirect happens are dropped as they return.
//
// Parameters
//   RESET_PC        PC loaded on reset
//   DEPTH           instruction buffer entries; also bounds in-flight + buffered
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   imem_req        fetch request valid
//   imem_addr       fetch word address, [1:0] always zero
//   imem_gnt        request accepted this cycle
//   imem_rvalid     read data valid, responses return in request order
//   imem_rdata      instruction word
//   redirect_valid  one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     new PC, [1:0] ignored
//   instr_valid     instr / instr_pc valid toward decode
//   instr_ready     decode accepts this cycle
//   instr           instruction word
//   instr_pc        PC of instr
//   instr_pc_plus4  instr_pc + 4 (mod 2^32)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned SumW = CntW + 1;
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StFetch,
        StWaitCredit,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [CntW-1:0]   outst_q, outst_d;
    logic [CntW-1:0]   buf_cnt_q, buf_cnt_d;
    logic [CntW-1:0]   drop_q, drop_d;
    logic [PtrW-1:0]   buf_rd_q, buf_rd_d;
    logic [PtrW-1:0]   buf_wr_q, buf_wr_d;
    logic [PtrW-1:0]   pcq_rd_q, pcq_rd_d;
    logic [PtrW-1:0]   pcq_wr_q, pcq_wr_d;

    // Storage: word buffer with its PCs, and the in-order address queue of
    // requests still waiting for their response.
    logic [31:0]       buf_instr_q [DEPTH];
    logic [31:0]       buf_pc_q    [DEPTH];
    logic [31:0]       pcq_q       [DEPTH];

    logic              credit;
    logic              credit_next;
    logic              grant;
    logic              resp;
    logic              push;
    logic              pop;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Handshakes and request generation
    always_comb begin
        credit    = ({1'b0, outst_q} + {1'b0, buf_cnt_q}) < SumW'(DEPTH);
        // Gated by reset so nothing is requested while reset is held.
        imem_req  = reset && credit && (state_q != StDrain) && !redirect_valid;
        imem_addr = {pc_q[31:2], 2'b00};
        grant     = imem_req && imem_gnt;
        // A response with nothing outstanding cannot belong to us; ignore it.
        resp      = imem_rvalid && (outst_q != '0);
        push      = resp && (drop_q == '0) && !redirect_valid;
        pop       = instr_valid && instr_ready && !redirect_valid;
    end

    // Next-state
    always_comb begin
        pc_d      = grant ? pc_q + 32'd4 : pc_q;
        outst_d   = outst_q + CntW'(grant) - CntW'(resp);
        drop_d    = (resp && (drop_q != '0)) ? drop_q - CntW'(1) : drop_q;
        buf_cnt_d = buf_cnt_q + CntW'(push) - CntW'(pop);
        buf_wr_d  = push ? ptr_inc(buf_wr_q) : buf_wr_q;
        buf_rd_d  = pop ? ptr_inc(buf_rd_q) : buf_rd_q;
        pcq_wr_d  = grant ? ptr_inc(pcq_wr_q) : pcq_wr_q;
        pcq_rd_d  = resp ? ptr_inc(pcq_rd_q) : pcq_rd_q;

        if (redirect_valid) begin
            pc_d      = {redirect_pc[31:2], 2'b00};
            // Every response still owed after this cycle is now stale.
            drop_d    = outst_d;
            buf_cnt_d = '0;
            buf_wr_d  = '0;
            buf_rd_d  = '0;
        end

        credit_next = ({1'b0, outst_d} + {1'b0, buf_cnt_d}) < SumW'(DEPTH);

        state_d = state_q;
        case (state_q)
            StFetch:      if (!credit_next) state_d = StWaitCredit;
            StWaitCredit: if (credit_next) state_d = StFetch;
            StDrain:      if (drop_d == '0) state_d = StFetch;
            default:      state_d = StFetch;
        endcase
        if (redirect_valid) begin
            state_d = (drop_d != '0) ? StDrain : StFetch;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StFetch;
            pc_q      <= {RESET_PC[31:2], 2'b00};
            outst_q   <= '0;
            buf_cnt_q <= '0;
            drop_q    <= '0;
            buf_rd_q  <= '0;
            buf_wr_q  <= '0;
            pcq_rd_q  <= '0;
            pcq_wr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            buf_cnt_q <= buf_cnt_d;
            drop_q    <= drop_d;
            buf_rd_q  <= buf_rd_d;
            buf_wr_q  <= buf_wr_d;
            pcq_rd_q  <= pcq_rd_d;
            pcq_wr_q  <= pcq_wr_d;
        end
    end

    // Data storage needs no reset: occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            buf_instr_q[buf_wr_q] <= imem_rdata;
            buf_pc_q[buf_wr_q]    <= pcq_q[pcq_rd_q];
        end
        if (grant) begin
            pcq_q[pcq_wr_q] <= imem_addr;
        end
    end

    // Decode-side outputs straight from the buffer head
    always_comb begin
        instr_valid    = (buf_cnt_q != '0);
        instr          = buf_instr_q[buf_rd_q];
        instr_pc       = buf_pc_q[buf_rd_q];
        instr_pc_plus4 = buf_pc_q[buf_rd_q] + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 3;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc, instr_pc_plus4;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_p4;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    // Second instance only observed during the first few cycles after reset.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (w_valid),
        .instr_ready    (instr_ready),
        .instr          (w_instr),
        .instr_pc       (w_pc),
        .instr_pc_plus4 (w_p4)
    );

    typedef struct {
        logic [31:0] addr;
        bit          live;
        int          due;
    } mem_t;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          vld;
        logic [31:0] pc;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          p_rv  = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          last_due = 0;

    // Reference model: memory pipe, words expected by decode, returned count
    mem_t        mem_q[$];
    logic [31:0] exp_q[$];
    int          n_ret = 0;
    logic [31:0] model_pc = RESET_PC;

    bit          hold_prev = 0;
    logic [31:0] prev_pc, prev_instr;

    bit          s_req, s_vld, s_wreq, s_wvld;
    logic [31:0] s_addr, s_pc, s_waddr, s_wpc, s_wp4;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (mem_q[i]) if (!mem_q[i].live) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk("rst_req", imem_req, 1'b0);
            chk("rst_valid", instr_valid, 1'b0);
        end
        mem_q.delete();
        exp_q.delete();
        n_ret     = 0;
        model_pc  = RESET_PC;
        hold_prev = 0;
        last_due  = 0;
        reset     = 1'b1;
    endtask

    task automatic cycle(input bit g, input bit r, input bit rd, input logic [31:0] rpc);
        bit          rv;
        bit          exp_req;
        mem_t        m;
        int          d;
        imem_gnt       = g;
        instr_ready    = r;
        redirect_valid = rd;
        redirect_pc    = rpc;
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rv);
        imem_rvalid = rv;
        imem_rdata  = rv ? word_of(mem_q[0].addr) : 32'h0;
        #1;
        exp_req = (mem_q.size() + n_ret < DEPTH) && (stale_cnt() == 0) && !rd;
        chk("req", imem_req, exp_req);
        if (imem_req) chk("addr", imem_addr, model_pc);
        chk("valid", instr_valid, n_ret != 0);
        if (instr_valid && n_ret != 0) begin
            chk("instr_pc", instr_pc, exp_q[0]);
            chk("instr", instr, word_of(exp_q[0]));
            chk("pc_plus4", instr_pc_plus4, exp_q[0] + 32'd4);
        end
        if (hold_prev) begin
            chk("hold_pc", instr_pc, prev_pc);
            chk("hold_instr", instr, prev_instr);
        end
        s_req = imem_req;  s_addr = imem_addr;  s_vld = instr_valid;  s_pc = instr_pc;
        s_wreq = w_req;    s_waddr = w_addr;    s_wvld = w_valid;     s_wpc = w_pc;
        s_wp4 = w_p4;
        // Apply this edge's events to the model
        if (instr_valid && r && n_ret != 0) begin
            void'(exp_q.pop_front());
            n_ret--;
        end
        if (rv) begin
            m = mem_q.pop_front();
            if (m.live && !rd) n_ret++;
        end
        if (imem_req && g) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d < last_due) d = last_due;
            last_due = d;
            mem_q.push_back('{addr: model_pc, live: 1'b1, due: d});
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        if (rd) begin
            exp_q.delete();
            n_ret = 0;
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            model_pc = {rpc[31:2], 2'b00};
        end
        hold_prev  = instr_valid && !r && !rd;
        prev_pc    = instr_pc;
        prev_instr = instr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        vec_t tbl [20];
        int   n;
        bit   found;

        tbl[0]  = '{1, 1, 1, 32'd0,  0, 32'd0};
        tbl[1]  = '{0, 1, 1, 32'd4,  0, 32'd0};
        tbl[2]  = '{0, 1, 1, 32'd8,  1, 32'd0};
        tbl[3]  = '{0, 1, 1, 32'd12, 1, 32'd4};
        tbl[4]  = '{0, 1, 1, 32'd16, 1, 32'd8};
        tbl[5]  = '{1, 0, 1, 32'd0,  0, 32'd0};
        tbl[6]  = '{0, 0, 1, 32'd4,  0, 32'd0};
        tbl[7]  = '{0, 0, 1, 32'd8,  1, 32'd0};
        for (int i = 8; i < 15; i++) tbl[i] = '{0, 0, 0, 32'd0, 1, 32'd0};
        tbl[15] = '{0, 1, 0, 32'd0,  1, 32'd0};
        tbl[16] = '{0, 1, 1, 32'd12, 1, 32'd4};
        tbl[17] = '{0, 1, 1, 32'd16, 1, 32'd8};
        tbl[18] = '{0, 1, 1, 32'd20, 1, 32'd12};
        tbl[19] = '{0, 1, 1, 32'd24, 1, 32'd16};

        // Startup streaming, then a 10-cycle decode stall from a fresh reset
        p_rv = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].rst) do_reset(2);
            cycle(1'b1, tbl[i].rdy, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_vld", i), s_vld, tbl[i].vld);
            if (tbl[i].vld) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
            if (i == 0) chk("wrap_addr0", s_waddr, 32'hFFFF_FFFC);
            if (i == 1) chk("wrap_addr1", s_waddr, 32'h0000_0000);
            if (i == 2) begin
                chk("wrap_vld", s_wvld, 1'b1);
                chk("wrap_pc", s_wpc, 32'hFFFF_FFFC);
                chk("wrap_plus4", s_wp4, 32'h0000_0000);
            end
        end

        // Redirect with two requests in flight
        do_reset(2);
        lat_min = 3; lat_max = 3;
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("c_redir_req", s_req, 1'b0);
        n = 0; found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_req) found = 1; else n++;
        end
        chk("c_req_back", found, 1'b1);
        chk("c_drain_len", n, 2);
        chk("c_addr", s_addr, 32'h0000_0100);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_vld) found = 1;
        end
        chk("c_vld_seen", found, 1'b1);
        chk("c_first_pc", s_pc, 32'h0000_0100);

        // Redirect coinciding with gnt and rvalid
        do_reset(2);
        lat_min = 2; lat_max = 2;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0202);
        chk("d_redir_req", s_req, 1'b0);
        n = 0; found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_req) found = 1; else n++;
        end
        chk("d_req_back", found, 1'b1);
        chk("d_drop_len", n, 1);
        chk("d_addr", s_addr, 32'h0000_0200);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_vld) found = 1;
        end
        chk("d_vld_seen", found, 1'b1);
        chk("d_first_pc", s_pc, 32'h0000_0200);

        // Reset with words buffered and in flight
        do_reset(2);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        do_reset(3);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("e_req", s_req, 1'b1);
        chk("e_addr", s_addr, RESET_PC);

        // Randomized traffic against the model
        p_rv = 70; lat_min = 1; lat_max = 3;
        for (int k = 0; k < 4000; k++) begin
            cycle($urandom_range(99) < 70, $urandom_range(99) < 60,
                  $urandom_range(99) < 3, $urandom);
        end
        p_rv = 100;
        for (int k = 0; k < 30; k++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drain_exp_empty", exp_q.size(), 0);
        chk("drain_mem_empty", mem_q.size(), 0);
        chk("drain_valid", instr_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
